// File: rtl/time_tmr_retry_issuer.sv
// Time-redundant TMR transmitter: tags each upstream item with a rolling ID, emits it
// Repeats times back-to-back, and keeps a short history so the voter can request a re-issue.
module time_tmr_retry_issuer #(
  parameter int DataWidth = 8,
  parameter int IDSize    = 4,
  parameter int Repeats   = 3,
  parameter int Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IDSize-1:0]    id_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 retry_valid_i,
  input  logic [IDSize-1:0]    retry_id_i,
  output logic                 retry_ready_o,
  output logic                 retry_miss_o
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Repeats);

  typedef enum logic [1:0] {IDLE, ISSUE, RETRY} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IDSize-1:0]      next_id, next_id_n;
  logic [IDSize-1:0]      fill, fill_n;
  logic [DataWidth-1:0]   data_q, data_n;
  logic [IDSize-1:0]      id_q, id_n;
  logic                   valid_q;
  logic                   miss_n;
  logic                   hist_we;
  logic [DataWidth-1:0]   hist [Depth];

  logic                   busy, last_copy, dp, pass, hit;
  logic [IDSize-1:0]      age, fill_inc;

  assign busy      = (state != IDLE);
  assign last_copy = busy && (cnt == CW'(Repeats - 1)) && ready_i;
  assign dp        = !busy || last_copy;
  // Pass-through is only entered from IDLE so an in-flight item always finishes its copies.
  assign pass      = !busy && !enable_i;
  assign age       = next_id - retry_id_i;
  assign hit       = (age != '0) && (age <= fill);
  assign fill_inc  = (fill == IDSize'(Depth)) ? fill : fill + 1'b1;

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    next_id_n     = next_id;
    fill_n        = fill;
    data_n        = data_q;
    id_n          = id_q;
    miss_n        = 1'b0;
    hist_we       = 1'b0;
    ready_o       = 1'b0;
    retry_ready_o = 1'b0;

    if (busy && ready_i && !last_copy) cnt_n = cnt + 1'b1;
    if (last_copy) state_n = IDLE;

    if (pass) begin
      ready_o = ready_i;
      if (valid_i && ready_i) begin
        hist_we   = 1'b1;
        next_id_n = next_id + 1'b1;
        fill_n    = fill_inc;
      end
    end else if (dp && enable_i) begin
      // A pending retry outranks new upstream data at every decision point.
      if (retry_valid_i) begin
        retry_ready_o = 1'b1;
        if (hit) begin
          data_n  = hist[retry_id_i[AW-1:0]];
          id_n    = retry_id_i;
          state_n = RETRY;
          cnt_n   = '0;
        end else begin
          miss_n  = 1'b1;
          state_n = IDLE;
        end
      end else begin
        ready_o = 1'b1;
        if (valid_i) begin
          hist_we   = 1'b1;
          data_n    = data_i;
          id_n      = next_id;
          next_id_n = next_id + 1'b1;
          fill_n    = fill_inc;
          state_n   = ISSUE;
          cnt_n     = '0;
        end
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      next_id      <= '0;
      fill         <= '0;
      data_q       <= '0;
      id_q         <= '0;
      valid_q      <= 1'b0;
      retry_miss_o <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      next_id      <= next_id_n;
      fill         <= fill_n;
      data_q       <= data_n;
      id_q         <= id_n;
      valid_q      <= (state_n != IDLE);
      retry_miss_o <= miss_n;
    end
  end

  // NOTE: history has no reset; entries are invalidated logically by clearing fill.
  always_ff @(posedge clk_i) begin
    if (hist_we) hist[next_id[AW-1:0]] <= data_i;
  end

  assign valid_o = pass ? valid_i : valid_q;
  assign data_o  = pass ? data_i  : data_q;
  assign id_o    = pass ? next_id : id_q;

endmodule

// File: tb/tb_time_tmr_retry_issuer.sv
// Directed bench for time_tmr_retry_issuer: issue, backpressure, retry hit/miss,
// pass-through, reset abort and ID wrap, with immediate-assertion checks.
module tb_time_tmr_retry_issuer;

  logic       clk = 1'b0;
  logic       rst, en, vin, rdy, rv;
  logic [7:0] din;
  logic [3:0] rid;
  logic       ready_o, valid_o, retry_ready_o, retry_miss_o;
  logic [7:0] data_o;
  logic [3:0] id_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_tmr_retry_issuer #(.DataWidth(8), .IDSize(4), .Repeats(3), .Depth(4)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .data_i(din), .valid_i(vin),
    .ready_o(ready_o), .data_o(data_o), .id_o(id_o), .valid_o(valid_o),
    .ready_i(rdy), .retry_valid_i(rv), .retry_id_i(rid),
    .retry_ready_o(retry_ready_o), .retry_miss_o(retry_miss_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one item from IDLE and let its three copies drain without backpressure.
  task automatic issue(input logic [7:0] d, input logic [3:0] exp_id);
    vin = 1'b1; din = d;
    #1 check("issue_ready", ready_o, 1);
    tick();
    vin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("issue_valid", valid_o, 1);
      check("issue_data", data_o, d);
      check("issue_id", id_o, exp_id);
      tick();
    end
    #1 check("issue_idle", valid_o, 0);
  endtask

  logic [7:0] exp_d [6];
  logic [3:0] exp_i [6];
  logic [3:0] pid;

  initial begin
    rst = 1'b1; en = 1'b1; vin = 1'b0; rdy = 1'b1; rv = 1'b0; din = 8'h00; rid = 4'h0;
    tick(); tick();
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_id", id_o, 0);
    check("rst_miss", retry_miss_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_rready", retry_ready_o, 0);
    rst = 1'b0;
    tick();

    // 1: two items back-to-back, no bubble between them
    exp_d = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h3C, 8'h3C};
    exp_i = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    vin = 1'b1; din = 8'hA5;
    tick();
    din = 8'h3C;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t1_valid", valid_o, 1);
      check("t1_data", data_o, exp_d[k]);
      check("t1_id", id_o, exp_i[k]);
      if (k == 0) check("t1_busy_ready", ready_o, 0);
      if (k == 2) check("t1_chain_ready", ready_o, 1);
      tick();
      if (k == 2) vin = 1'b0;
    end
    #1 check("t1_idle", valid_o, 0);

    // 2: stall the second copy for three cycles
    vin = 1'b1; din = 8'h5A;
    tick();
    vin = 1'b0;
    #1 check("t2_c1_data", data_o, 8'h5A);
    tick();
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t2_stall_valid", valid_o, 1);
      check("t2_stall_data", data_o, 8'h5A);
      check("t2_stall_id", id_o, 2);
      tick();
    end
    rdy = 1'b1;
    #1 check("t2_c2_valid", valid_o, 1);
    tick();
    #1 check("t2_c3_valid", valid_o, 1);
    check("t2_c3_id", id_o, 2);
    tick();
    #1 check("t2_done", valid_o, 0);

    // 3: fill IDs 3..5, then retry ID 3 while upstream also offers data
    issue(8'h33, 4'd3);
    issue(8'h44, 4'd4);
    issue(8'h55, 4'd5);
    rv = 1'b1; rid = 4'd3; vin = 1'b1; din = 8'h66;
    #1;
    check("t3_rready", retry_ready_o, 1);
    check("t3_up_blocked", ready_o, 0);
    tick();
    rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_rt_valid", valid_o, 1);
      check("t3_rt_data", data_o, 8'h33);
      check("t3_rt_id", id_o, 3);
      if (k == 2) check("t3_chain_ready", ready_o, 1);
      tick();
    end
    vin = 1'b0;
    #1;
    check("t3_new_data", data_o, 8'h66);
    check("t3_new_id", id_o, 6);
    tick(); tick(); tick();
    #1 check("t3_idle", valid_o, 0);

    // 4: retry ID 1 is too old (age 6)
    rv = 1'b1; rid = 4'd1;
    #1 check("t4_rready", retry_ready_o, 1);
    tick();
    rv = 1'b0;
    #1;
    check("t4_miss", retry_miss_o, 1);
    check("t4_no_valid", valid_o, 0);
    vin = 1'b1; din = 8'h77;
    #1 check("t4_resume_ready", ready_o, 1);
    tick();
    vin = 1'b0;
    #1;
    check("t4_miss_clear", retry_miss_o, 0);
    check("t4_data", data_o, 8'h77);
    check("t4_id", id_o, 7);
    tick(); tick(); tick();

    // 5: pass-through with random handshakes
    en = 1'b0; rv = 1'b1; rid = 4'd7;
    pid = 4'd8;
    for (int k = 0; k < 50; k++) begin
      vin = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      #1;
      check("t5_valid", valid_o, vin);
      check("t5_ready", ready_o, rdy);
      check("t5_data", data_o, din);
      check("t5_id", id_o, pid);
      if (k == 0) check("t5_rready", retry_ready_o, 0);
      tick();
      if (vin && rdy) pid = pid + 4'd1;
    end
    en = 1'b1; vin = 1'b0; rdy = 1'b1; rv = 1'b0;
    tick();

    // 6A: reset during the first copy aborts it and empties history
    vin = 1'b1; din = 8'hA1;
    tick();
    vin = 1'b0;
    #1 check("t6a_copy1", valid_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6a_valid", valid_o, 0);
    check("t6a_id", id_o, 0);
    rv = 1'b1; rid = 4'd0;
    #1 check("t6a_rready", retry_ready_o, 1);
    tick();
    rv = 1'b0;
    #1 check("t6a_miss", retry_miss_o, 1);
    tick();
    #1 check("t6a_miss_clear", retry_miss_o, 0);

    // 6B: 18 chained items wrap the ID, then retry ID 15 (age 3)
    vin = 1'b1; din = 8'd0;
    tick();
    for (int i = 0; i < 18; i++) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        check("t6b_valid", valid_o, 1);
        check("t6b_id", id_o, i % 16);
        check("t6b_data", data_o, i);
        if (c == 2) begin
          din = 8'(i + 1);
          vin = (i != 17);
        end
        tick();
      end
    end
    #1 check("t6b_idle", valid_o, 0);
    rv = 1'b1; rid = 4'd15;
    #1 check("t6b_rready", retry_ready_o, 1);
    tick();
    rv = 1'b0;
    #1;
    check("t6b_hit_nomiss", retry_miss_o, 0);
    check("t6b_hit_valid", valid_o, 1);
    check("t6b_hit_id", id_o, 15);
    check("t6b_hit_data", data_o, 8'd15);
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
